aes_req_arbiter: RTL and testbench
==================================

AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  TIMEOUT  255  max cycles waited for core_done after core_start; range 16..65535
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk             in   1    single clock, rising edge
  rst             in   1    asynchronous, active-high reset
  req_valid       in   2    bit i: requester i has a job
  req_ready       out  2    bit i: job from requester i accepted this cycle
  req_pt          in   256  {ch1[255:128], ch0[127:0]} plaintext
  req_key         in   256  {ch1, ch0} cipher key
  rsp_valid       out  1    result available
  rsp_ready       in   1    consumer accepts result
  rsp_id          out  1    requester index of result
  rsp_data        out  128  ciphertext; 0 when rsp_err=1
  rsp_err         out  1    core timed out
  core_start      out  1    one-cycle start pulse to aes_core
  core_plaintext  out  128  plaintext to core, stable from start until done
  core_key        out  128  key to core, stable from start until done
  core_ciphertext in   128  core result
  core_done       in   1    core completion pulse
REQ-003 The clock SHALL be named clk and the reset rst; rst SHALL be asynchronous and active-high.

Function
REQ-004 The block SHALL time-share one aes_core between two requesters, with one job in flight at a time.
REQ-005 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-006 IDLE: if any req_valid bit is set, req_ready SHALL be one-hot on the granted channel in the same cycle (combinational from req_valid); otherwise req_ready=0.
REQ-007 Grant is round-robin: a single valid wins; with both valid, the channel not equal to last_grant wins.
REQ-008 On the IDLE handshake, the block SHALL latch pt, key and id into holding registers, update last_grant, and go to ISSUE.
REQ-009 ISSUE: core_start=1 for exactly one cycle; go to WAIT and clear the timeout counter.
REQ-010 core_plaintext and core_key SHALL be driven from the holding registers and held constant from ISSUE until leaving WAIT.
REQ-011 WAIT: on core_done=1, capture core_ciphertext into rsp_data with rsp_err=0, then go to RESP.
REQ-012 WAIT: when the counter reaches TIMEOUT without core_done, set rsp_data=0 and rsp_err=1, then go to RESP; core_done and timeout in the same cycle resolve to done.
REQ-013 RESP: rsp_valid=1 and rsp_data/rsp_id/rsp_err SHALL be held stable until rsp_ready=1; on that handshake return to IDLE.
REQ-014 req_ready SHALL be 0 in ISSUE, WAIT and RESP; no new job is accepted until the response handshake completes.
REQ-015 core_done outside WAIT SHALL be ignored.
REQ-016 The timeout counter SHALL be 16 bits wide and saturating.
REQ-017 Nominal core latency is 13 cycles from the core_start cycle to core_done; the block SHALL NOT depend on this value.
REQ-018 Minimum job turnaround is handshake + ISSUE + core latency + one RESP cycle.

Reset
REQ-019 On rst: state=IDLE, last_grant=1 (so ch0 wins the first tie), and all outputs 0, including rsp_valid, rsp_data, rsp_err, rsp_id, core_start, core_plaintext and core_key.
REQ-020 rst mid-job SHALL abort the job with no response; the first job after reset starts cleanly.

Structure
REQ-021 The state encoding, the channel count (2), the data width (128) and the TIMEOUT default SHALL live in a shared package aes_pkg.
REQ-022 The block SHALL be a single module; a separate rr_arb2 grant sub-module is permitted.
REQ-023 The block SHALL not instantiate aes_core; the two are connected at the top level.

Verification (core stub: ct = pt^key, latency L; unless noted)
REQ-024 ch0 only, pt=0x0011..eeff, key=0x0001..0f, L=13 -> one core_start, rsp_id=0, rsp_data=pt^key, rsp_err=0.
REQ-025 ch0 and ch1 held valid for 4 jobs -> grants alternate 0,1,0,1; after reset the first grant goes to ch0.
REQ-026 Stub never asserts done, TIMEOUT=16 -> rsp_valid 17 cycles after core_start, with rsp_err=1 and rsp_data=0.
REQ-027 rsp_ready held low 20 cycles in RESP -> rsp_* stable, req_ready=0 throughout, no second core_start.
REQ-028 rst asserted mid-WAIT, then a new ch1 job -> no stale response; the ch1 result is correct.
REQ-029 Integration with the real aes_core: FIPS-197 key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared encoding and sizing for the AES request arbiter.
package aes_pkg;
   localparam int NCH         = 2;
   localparam int DW          = 128;
   localparam int TIMEOUT_DEF = 255;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
endpackage

// File: rtl/aes_req_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the channel not granted last wins.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] gnt
);
   always_comb gnt = (valid == 2'b11) ? (last ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: time-shares one AES core between two requesters, one job in flight.
module aes_req_arbiter
   import aes_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    req_valid,
   output logic [NCH-1:0]    req_ready,
   input  logic [NCH*DW-1:0] req_pt,
   input  logic [NCH*DW-1:0] req_key,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DW-1:0]     rsp_data,
   output logic              rsp_err,
   output logic              core_start,
   output logic [DW-1:0]     core_plaintext,
   output logic [DW-1:0]     core_key,
   input  logic [DW-1:0]     core_ciphertext,
   input  logic              core_done
);
   localparam logic [15:0] TO = 16'(TIMEOUT);
   state_e        state_q, state_d;
   logic          last_q, last_d, id_q, id_d, err_q, err_d;
   logic [DW-1:0] pt_q, pt_d, key_q, key_d, data_q, data_d;
   logic [15:0]   cnt_q, cnt_d, cnt_inc;
   logic [1:0]    gnt;

   rr_arb2 u_arb (.valid(req_valid), .last(last_q), .gnt(gnt));

   assign cnt_inc        = (cnt_q == 16'hffff) ? cnt_q : cnt_q + 16'd1;
   assign req_ready      = (state_q == IDLE) ? gnt : 2'b00;
   assign core_start     = state_q == ISSUE;
   assign rsp_valid      = state_q == RESP;
   assign rsp_id         = id_q;
   assign rsp_data       = data_q;
   assign rsp_err        = err_q;
   assign core_plaintext = pt_q;
   assign core_key       = key_q;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      pt_d    = pt_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (|gnt) begin
            pt_d    = gnt[1] ? req_pt[2*DW-1:DW] : req_pt[DW-1:0];
            key_d   = gnt[1] ? req_key[2*DW-1:DW] : req_key[DW-1:0];
            id_d    = gnt[1];
            last_d  = gnt[1];
            state_d = ISSUE;
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_inc;
            // done takes priority over a timeout landing in the same cycle
            if (core_done || cnt_inc == TO) begin
               data_d  = core_done ? core_ciphertext : '0;
               err_d   = !core_done;
               state_d = RESP;
            end
         end
         RESP: if (rsp_ready) state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         pt_q    <= '0;
         key_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         pt_q    <= pt_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter: table-driven check of the arbiter against an xor core stub of settable latency.
module tb_aes_req_arbiter;
   localparam logic [127:0] A0 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] E0 = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [127:0] A1 = 128'hffff0000ffff0000ffff0000ffff0000;
   localparam logic [127:0] K1 = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
   localparam logic [127:0] E1 = 128'hf0f00f0ff0f00f0ff0f00f0ff0f00f0f;

   logic         clk = 0, rst = 1;
   logic [1:0]   req_valid = 0, req_ready;
   logic [255:0] req_pt = {A1, A0}, req_key = {K1, K0};
   logic         rsp_valid, rsp_ready = 0, rsp_id, rsp_err, core_start, core_done;
   logic [127:0] rsp_data, core_plaintext, core_key, core_ciphertext;
   int           total = 0, bad = 0, starts = 0, lat = 13, k = 0;
   logic         act = 0;

   always #5 clk = ~clk;

   aes_req_arbiter #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_pt(req_pt), .req_key(req_key), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .core_start(core_start),
      .core_plaintext(core_plaintext), .core_key(core_key),
      .core_ciphertext(core_ciphertext), .core_done(core_done)
   );

   // core stub: done pulses lat cycles after the start cycle; lat=0 never completes
   assign core_done       = act && lat != 0 && k == lat;
   assign core_ciphertext = core_done ? core_plaintext ^ core_key : '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         act <= 0;
         k   <= 0;
      end else if (core_start) begin
         act <= 1;
         k   <= 1;
      end else if (act) begin
         if (core_done) act <= 0;
         else k <= k + 1;
      end
   end

   always @(posedge clk) if (!rst && core_start) starts <= starts + 1;

   task automatic chk(input string name, input logic [127:0] act_v, input logic [127:0] exp_v);
      total++;
      if (act_v !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act_v, exp_v);
      end
   endtask

   task automatic chk_reset_outs();
      chk("rst_rsp_valid", 128'(rsp_valid), 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", 128'(rsp_err), 0);
      chk("rst_rsp_id", 128'(rsp_id), 0);
      chk("rst_core_start", 128'(core_start), 0);
      chk("rst_core_pt", core_plaintext, 0);
      chk("rst_core_key", core_key, 0);
   endtask

   task automatic run_job(input logic [1:0] v, input int l, input logic eid,
                          input logic [127:0] edata, input logic eerr, input int ecyc, input int stall);
      int n, s0;
      lat = l;
      req_valid = v;
      #1;
      chk("req_ready_grant", 128'(req_ready), eid ? 128'd2 : 128'd1);
      s0 = starts;
      @(negedge clk);
      req_valid = 0;
      chk("core_start", 128'(core_start), 1);
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
         chk("core_pt_hold", core_plaintext, eid ? A1 : A0);
         chk("core_key_hold", core_key, eid ? K1 : K0);
      end
      chk("latency", 128'(n), 128'(ecyc));
      chk("rsp_valid", 128'(rsp_valid), 1);
      chk("rsp_id", 128'(rsp_id), 128'(eid));
      chk("rsp_data", rsp_data, edata);
      chk("rsp_err", 128'(rsp_err), 128'(eerr));
      req_valid = stall > 0 ? 2'b11 : 2'b00;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_valid", 128'(rsp_valid), 1);
         chk("stall_data", rsp_data, edata);
         chk("stall_id_err", {126'd0, rsp_id, rsp_err}, {126'd0, eid, eerr});
         chk("stall_ready", 128'(req_ready), 0);
      end
      chk("one_start", 128'(starts - s0), 1);
      req_valid = 0;
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      chk("rsp_drop", 128'(rsp_valid), 0);
   endtask

   typedef struct {
      logic [1:0]   valid;
      int           l;
      logic         id;
      logic [127:0] data;
      logic         err;
      int           cyc;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{2'b11, 13, 1'b0, E0, 1'b0, 14};
      vecs[1]  = '{2'b11, 13, 1'b1, E1, 1'b0, 14};
      vecs[2]  = '{2'b11, 13, 1'b0, E0, 1'b0, 14};
      vecs[3]  = '{2'b11, 13, 1'b1, E1, 1'b0, 14};
      vecs[4]  = '{2'b01, 13, 1'b0, E0, 1'b0, 14};
      vecs[5]  = '{2'b10, 5,  1'b1, E1, 1'b0, 6};
      vecs[6]  = '{2'b01, 0,  1'b0, 0,  1'b1, 17};
      vecs[7]  = '{2'b10, 16, 1'b1, E1, 1'b0, 17};
      vecs[8]  = '{2'b10, 15, 1'b1, E1, 1'b0, 16};
      vecs[9]  = '{2'b01, 1,  1'b0, E0, 1'b0, 2};
      vecs[10] = '{2'b01, 17, 1'b0, 0,  1'b1, 17};
      repeat (2) @(negedge clk);
      chk_reset_outs();
      chk("rst_req_ready", 128'(req_ready), 0);
      rst = 0;
      @(negedge clk);
      for (int i = 0; i < 11; i++)
         run_job(vecs[i].valid, vecs[i].l, vecs[i].id, vecs[i].data, vecs[i].err, vecs[i].cyc, 0);
      // response held back: everything frozen, no new job accepted
      run_job(2'b01, 13, 1'b0, E0, 1'b0, 14, 20);
      // reset in the middle of WAIT aborts the job silently
      lat = 0;
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = 0;
      repeat (5) @(negedge clk);
      rst = 1;
      #1;
      chk_reset_outs();
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid || core_start) chk("no_stale", {126'd0, rsp_valid, core_start}, 0);
      end
      chk("idle_after_rst", 128'(rsp_valid), 0);
      run_job(2'b10, 13, 1'b1, E1, 1'b0, 14, 0);
      run_job(2'b11, 13, 1'b0, E0, 1'b0, 14, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
